dmem_resp: RTL and testbench

- Data-memory responder at the far end of the CPU load/store interface (memread, memwrite, address, writedata in; readdata out).
- Adds a ready handshake and programmable wait states, so the datapath can be tested against a slow memory.
- Holds a word-addressed internal array.
- Sits between the CPU data port and the system bus / testbench.

---
 rtl/dmem_resp_if.sv | 28 ++
 rtl/dmem_resp.sv | 127 ++++++++++++
 tb/tb_dmem_resp.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_resp_if.sv
// dmem_resp_if: CPU data-port bundle between a load/store requester and the
// dmem_resp memory responder.
//
// Handshake: the requester raises memread or memwrite (with addr/writedata)
// and holds it until ready is seen; ready is a one-cycle completion pulse
// and the requester drops its request during that ready cycle. err is only
// ever high together with ready. busy is high while a transaction is in
// flight.
interface dmem_resp_if;
    logic        memread;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        ready;
    logic        busy;
    logic        err;

    modport master (
        output memread, memwrite, addr, writedata,
        input  readdata, ready, busy, err
    );

    modport slave (
        input  memread, memwrite, addr, writedata,
        output readdata, ready, busy, err
    );
endinterface

// File: rtl/dmem_resp.sv
// dmem_resp: word-addressed data memory with a ready handshake and a
// programmable number of wait states (WAIT_CYCLES, 0..15).
//
// A request is captured in IDLE, counted down in WAIT, and the array access
// happens on the WAIT->RESP edge; RESP is the single ready cycle.
//
// Optional feature, macro DMEM_ALIGN_CHECK_EN: when defined, a captured
// address with addr[1:0] != 0 raises err alongside ready and the access is
// suppressed (no store, readdata unchanged). When undefined, err is 0 and
// the low address bits are simply ignored.
module dmem_resp #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic          clk,
    input  logic          reset,
    dmem_resp_if.slave    bus,
    output logic [1:0]    dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    state_t                  state_q;
    logic [3:0]              cnt_q;
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic [31:0]             wdata_q;
    logic                    wr_q;
    logic [31:0]             readdata_q;
    logic                    ready_q;
    logic                    err_q;
    logic [31:0]             mem_q [DEPTH];

    logic                    misal;
    logic                    access;
    logic                    mem_we;

    // Address bits outside the word index only matter for the alignment check.
    logic                    unused_addr_bits;
    assign unused_addr_bits = ^{bus.addr[31:ADDR_WIDTH+2], bus.addr[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
    logic [1:0]              off_q;
    assign misal = (off_q != 2'b00);
`else
    assign misal = 1'b0;
`endif

    // The access edge is the last WAIT edge; a reset before it leaves the array untouched.
    assign access = (state_q == S_WAIT) && (cnt_q == 4'd0);
    assign mem_we = access && wr_q && !misal;

    // Request capture, wait countdown, read access and registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            idx_q      <= '0;
            wdata_q    <= 32'd0;
            wr_q       <= 1'b0;
            readdata_q <= 32'd0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
            off_q      <= 2'b00;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    if (bus.memread || bus.memwrite) begin
                        idx_q   <= bus.addr[ADDR_WIDTH+1:2];
                        wdata_q <= bus.writedata;
                        wr_q    <= bus.memwrite;   // store wins over load
                        cnt_q   <= 4'(WAIT_CYCLES);
`ifdef DMEM_ALIGN_CHECK_EN
                        off_q   <= bus.addr[1:0];
`endif
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= S_RESP;
                        ready_q <= 1'b1;
                        err_q   <= misal;
                        if (!wr_q && !misal) begin
                            readdata_q <= mem_q[idx_q];
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Array store; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign bus.readdata = readdata_q;
    assign bus.ready    = ready_q;
    assign bus.err      = err_q;
    assign bus.busy     = (state_q != S_IDLE);
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_dmem_resp.sv
// tb_dmem_resp: directed bench for dmem_resp. Two instances share clock and
// reset: u_w2 (WAIT_CYCLES=2) and u_w0 (WAIT_CYCLES=0). Each issued request
// pushes {expected ready cycle, expected err, expected readdata} into a
// per-instance queue; a monitor per instance pops and compares on ready.
`timescale 1ns/1ps
module tb_dmem_resp;

    localparam int EW = 49;   // {cyc[15:0], err, readdata[31:0]}

    logic clk;
    logic reset;
    int   cyc;
    int   n_cmp;
    int   n_mis;

    logic [EW-1:0] exp2_q[$];
    logic [EW-1:0] exp0_q[$];

    logic [1:0] dbg2;
    logic [1:0] dbg0;

    dmem_resp_if b2 ();
    dmem_resp_if b0 ();

    dmem_resp #(.ADDR_WIDTH(8), .WAIT_CYCLES(2)) u_w2 (
        .clk         (clk),
        .reset       (reset),
        .bus         (b2),
        .dbg_state_o (dbg2)
    );

    dmem_resp #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) u_w0 (
        .clk         (clk),
        .reset       (reset),
        .bus         (b0),
        .dbg_state_o (dbg0)
    );

`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- comparison helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitors / scoreboard ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (b2.err && !b2.ready) chk("w2_err_without_ready", 32'(b2.err), 32'd0);
        if (b2.ready) begin
            if (exp2_q.size() == 0) begin
                chk("w2_unexpected_ready", 32'(b2.ready), 32'd0);
            end else begin
                e = exp2_q.pop_front();
                chk("w2_readdata", b2.readdata, e[31:0]);
                chk("w2_err", 32'(b2.err), 32'(e[32]));
                chk("w2_ready_cycle", 32'(cyc[15:0]), 32'(e[48:33]));
                chk("w2_busy_in_resp", 32'(b2.busy), 32'd1);
            end
        end
    end

    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (b0.err && !b0.ready) chk("w0_err_without_ready", 32'(b0.err), 32'd0);
        if (b0.ready) begin
            if (exp0_q.size() == 0) begin
                chk("w0_unexpected_ready", 32'(b0.ready), 32'd0);
            end else begin
                e = exp0_q.pop_front();
                chk("w0_readdata", b0.readdata, e[31:0]);
                chk("w0_err", 32'(b0.err), 32'(e[32]));
                chk("w0_ready_cycle", 32'(cyc[15:0]), 32'(e[48:33]));
            end
        end
    end

    // ---------------- driver ----------------
    // inst 1 -> WAIT_CYCLES=2 instance, inst 0 -> WAIT_CYCLES=0 instance.
    task automatic run_op(input bit inst, input bit rd, input bit wr,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err);
        bit got;
        int w;
        got = 1'b0;
        w   = inst ? 2 : 0;
        @(negedge clk);
        // Sampled at the next posedge (E0); ready seen w+1 edges later.
        if (inst) begin
            b2.memread = rd; b2.memwrite = wr; b2.addr = a; b2.writedata = wd;
            exp2_q.push_back({16'(cyc + w + 2), exp_err, exp_rd});
        end else begin
            b0.memread = rd; b0.memwrite = wr; b0.addr = a; b0.writedata = wd;
            exp0_q.push_back({16'(cyc + w + 2), exp_err, exp_rd});
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((inst && b2.ready) || (!inst && b0.ready)) begin
                got = 1'b1;
                break;
            end
        end
        if (inst) begin
            b2.memread = 1'b0; b2.memwrite = 1'b0;
        end else begin
            b0.memread = 1'b0; b0.memwrite = 1'b0;
        end
        if (!got) begin
            chk(inst ? "w2_ready_timeout" : "w0_ready_timeout", 32'd0, 32'd1);
            if (inst && exp2_q.size() != 0) void'(exp2_q.pop_front());
            if (!inst && exp0_q.size() != 0) void'(exp0_q.pop_front());
        end
        @(negedge clk);
        chk(inst ? "w2_busy_idle" : "w0_busy_idle", 32'(inst ? b2.busy : b0.busy), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_cmp = 0;
        n_mis = 0;
        cyc   = 0;
        b2.memread = 1'b0; b2.memwrite = 1'b0; b2.addr = 32'd0; b2.writedata = 32'd0;
        b0.memread = 1'b0; b0.memwrite = 1'b0; b0.addr = 32'd0; b0.writedata = 32'd0;

        // Asynchronous reset, checked before the first clock edge.
        reset = 1'b1;
        #2;
        chk("rst_ready", 32'(b2.ready), 32'd0);
        chk("rst_busy", 32'(b2.busy), 32'd0);
        chk("rst_readdata", b2.readdata, 32'd0);
        chk("rst_err", 32'(b2.err), 32'd0);
        chk("rst_state", 32'(dbg2), 32'd0);
        #10 reset = 1'b0;

        // Write then read, 2 wait states.
        run_op(1'b1, 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0);
        run_op(1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0);

        // Write priority: readdata keeps the prior load value.
        run_op(1'b1, 1'b1, 1'b1, 32'h0000_0020, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 1'b0);
        run_op(1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'h0,         32'hA5A5_A5A5, 1'b0);

        // Known contents at 0x30.
        run_op(1'b1, 1'b0, 1'b1, 32'h0000_0030, 32'h0BAD_C0DE, 32'hA5A5_A5A5, 1'b0);
        run_op(1'b1, 1'b1, 1'b0, 32'h0000_0030, 32'h0,         32'h0BAD_C0DE, 1'b0);

        // Reset during WAIT drops the store and clears outputs at once.
        @(negedge clk);
        b2.memwrite = 1'b1; b2.addr = 32'h0000_0030; b2.writedata = 32'hCAFE_F00D;
        @(negedge clk);
        b2.memwrite = 1'b0;
        chk("mid_busy_before_reset", 32'(b2.busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(b2.ready), 32'd0);
        chk("mid_rst_busy", 32'(b2.busy), 32'd0);
        chk("mid_rst_readdata", b2.readdata, 32'd0);
        chk("mid_rst_err", 32'(b2.err), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        run_op(1'b1, 1'b1, 1'b0, 32'h0000_0030, 32'h0, 32'h0BAD_C0DE, 1'b0);

        // Misalignment.
        run_op(1'b1, 1'b0, 1'b1, 32'h0000_0040, 32'h2222_2222, 32'h0BAD_C0DE, 1'b0);
        run_op(1'b1, 1'b0, 1'b1, 32'h0000_0042, 32'h1111_1111, 32'h0BAD_C0DE, ALIGN);
        run_op(1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0,
               ALIGN ? 32'h2222_2222 : 32'h1111_1111, 1'b0);
        run_op(1'b1, 1'b1, 1'b0, 32'h0000_0013, 32'h0,
               ALIGN ? 32'h2222_2222 : 32'hDEAD_BEEF, ALIGN);

        // Aliasing with zero wait states.
        run_op(1'b0, 1'b0, 1'b1, 32'h0000_0404, 32'h1234_5678, 32'h0000_0000, 1'b0);
        run_op(1'b0, 1'b1, 1'b0, 32'h0000_0004, 32'h0,         32'h1234_5678, 1'b0);
        run_op(1'b0, 1'b0, 1'b1, 32'h0000_0008, 32'h55AA_55AA, 32'h1234_5678, 1'b0);
        run_op(1'b0, 1'b1, 1'b0, 32'hFFFF_F408, 32'h0,         32'h55AA_55AA, 1'b0);

        // Drain and confirm every expected response arrived.
        for (int i = 0; i < 20; i++) begin
            if (exp2_q.size() == 0 && exp0_q.size() == 0) break;
            @(negedge clk);
        end
        chk("w2_queue_empty", 32'(exp2_q.size()), 32'd0);
        chk("w0_queue_empty", 32'(exp0_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
